// File: rtl/keypad_scanner.sv
// 3x3 key matrix scanner: drives one active-low column at a time, samples the
// synchronized rows, debounces full-matrix snapshots and flags single new presses.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_matrix_row,
  output logic [2:0] key_matrix_col,
  output logic [8:0] key_map,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int TickW = $clog2(SCAN_TICKS);
  localparam int CntW  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TickW-1:0] LastTick = TickW'(SCAN_TICKS - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {COL0, COL1, COL2} col_state_e;

  col_state_e       state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       sync1_q, sync2_q;
  logic [8:0]       raw_q, raw_d;
  logic [8:0]       prev_q, prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [8:0]       map_q, map_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic             held_q;
  logic             lastTick;
  logic             snapshot;
  logic [3:0]       ones;
  logic [3:0]       idx;

  always_comb begin
    lastTick = (tick_q == LastTick);
    raw_d    = raw_q;
    state_d  = state_q;
    tick_d   = tick_q + TickW'(1);
    col_d    = col_q;
    if (lastTick) begin
      tick_d = '0;
      for (int r = 0; r < 3; r++) begin
        case (state_q)
          COL0:    raw_d[3*r]   = ~sync2_q[r];
          COL1:    raw_d[3*r+1] = ~sync2_q[r];
          default: raw_d[3*r+2] = ~sync2_q[r];
        endcase
      end
      case (state_q)
        COL0:    begin state_d = COL1; col_d = 3'b101; end
        COL1:    begin state_d = COL2; col_d = 3'b011; end
        default: begin state_d = COL0; col_d = 3'b110; end
      endcase
    end

    // raw_d already holds the COL2 bits written this cycle, so it is the full snapshot
    snapshot = lastTick && (state_q == COL2);
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 9; i++) begin
      if (raw_d[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end

    cnt_d   = cnt_q;
    prev_d  = prev_q;
    map_d   = map_q;
    valid_d = 1'b0;
    code_d  = code_q;
    if (snapshot) begin
      if (raw_d == prev_q) begin
        cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);
      end else begin
        cnt_d = CntW'(1);
      end
      prev_d = raw_d;
      if (cnt_d == CntMax) begin
        map_d = raw_d;
        if ((map_q == '0) && (ones == 4'd1)) begin
          valid_d = 1'b1;
          code_d  = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= COL0;
      tick_q  <= '0;
      col_q   <= 3'b110;
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      raw_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= CntMax;
      map_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
      sync1_q <= key_matrix_row;
      sync2_q <= sync1_q;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      held_q  <= |map_d;
    end
  end

  assign key_matrix_col = col_q;
  assign key_map        = map_q;
  assign key_valid      = valid_q;
  assign key_code       = code_q;
  assign key_held       = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a pressed-key matrix model drives the rows, and a
// cycle-count based reference model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int ScanTicks     = 4;
  localparam int DebounceScans = 2;
  localparam int ScanCycles    = 3 * ScanTicks;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] keys = '0;
  logic [2:0] keyMatrixRow;
  logic [2:0] keyMatrixCol;
  logic [8:0] keyMap;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyHeld;

  int vectors = 0;
  int miscompares = 0;

  int         edgeCount = 0;
  int         pulseCount = 0;
  int         lastPulseEdge = 0;
  logic [3:0] lastPulseCode = '0;

  bit         modelReady = 0;
  int         mCyc;
  logic [2:0] mH1, mH2, rowNow, rowSync;
  logic [8:0] mRaw, mPrev, mMap;
  int         mCnt;
  logic       mValid, mHeld;
  logic [3:0] mCode;
  logic [2:0] mCol;

  keypad_scanner #(
    .SCAN_TICKS     (ScanTicks),
    .DEBOUNCE_SCANS (DebounceScans)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_matrix_row (keyMatrixRow),
    .key_matrix_col (keyMatrixCol),
    .key_map        (keyMap),
    .key_valid      (keyValid),
    .key_code       (keyCode),
    .key_held       (keyHeld)
  );

  always #5 clk = ~clk;

  // A row is pulled low whenever a pressed key sits on a column being driven low
  always_comb begin
    keyMatrixRow = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!keyMatrixCol[c] && keys[3*r+c]) keyMatrixRow[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: position in the scan comes from a cycle count modulo one scan
  initial begin
    forever begin
      @(posedge clk);
      rowNow = keyMatrixRow;
      if (!reset) begin
        modelReady = 1;
        mCyc = 0;
        mH1 = 3'b111;
        mH2 = 3'b111;
        mRaw = '0;
        mPrev = '0;
        mMap = '0;
        mCnt = DebounceScans;
        mValid = 1'b0;
        mCode = '0;
      end else if (modelReady) begin
        rowSync = mH2;
        mH2 = mH1;
        mH1 = rowNow;
        mValid = 1'b0;
        if ((mCyc % ScanTicks) == ScanTicks - 1) begin
          for (int r = 0; r < 3; r++) mRaw[3*r + (mCyc / ScanTicks)] = ~rowSync[r];
          if ((mCyc / ScanTicks) == 2) begin
            if (mRaw == mPrev) mCnt = (mCnt + 1 > DebounceScans) ? DebounceScans : mCnt + 1;
            else mCnt = 1;
            mPrev = mRaw;
            if (mCnt == DebounceScans) begin
              if (mMap == '0 && $countones(mRaw) == 1) begin
                mValid = 1'b1;
                for (int i = 0; i < 9; i++) if (mRaw[i]) mCode = 4'(i);
              end
              mMap = mRaw;
            end
          end
        end
        mCyc = (mCyc + 1) % ScanCycles;
      end
      mHeld = (mMap != '0);
      mCol = ~(3'b001 << ((mCyc / ScanTicks) % 3));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (modelReady) begin
        checkOutput("key_matrix_col", 32'(keyMatrixCol), 32'(mCol));
        checkOutput("key_map", 32'(keyMap), 32'(mMap));
        checkOutput("key_valid", 32'(keyValid), 32'(mValid));
        checkOutput("key_code", 32'(keyCode), 32'(mCode));
        checkOutput("key_held", 32'(keyHeld), 32'(mHeld));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      edgeCount++;
      if (keyValid) begin
        pulseCount++;
        lastPulseCode = keyCode;
        lastPulseEdge = edgeCount;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [8:0] k, input int cycles);
    keys = k;
    waitCycles(cycles);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_col"}, 32'(keyMatrixCol), 32'(3'b110));
    checkOutput({tag, "_map"}, 32'(keyMap), 32'(0));
    checkOutput({tag, "_valid"}, 32'(keyValid), 32'(0));
    checkOutput({tag, "_code"}, 32'(keyCode), 32'(0));
    checkOutput({tag, "_held"}, 32'(keyHeld), 32'(0));
  endtask

  initial begin
    logic [2:0] colSeq [13];
    int p0, c0;
    bit found;
    logic [8:0] k;
    int sel;

    colSeq = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101,
               3'b011, 3'b011, 3'b011, 3'b011, 3'b110};
    reset = 1'b0;
    keys = '0;
    waitCycles(3);
    checkResetValues("reset");
    checkOutput("colseq0", 32'(keyMatrixCol), 32'(colSeq[0]));
    reset = 1'b1;
    for (int i = 1; i < 13; i++) begin
      @(negedge clk);
      checkOutput($sformatf("colseq%0d", i), 32'(keyMatrixCol), 32'(colSeq[i]));
    end
    waitCycles(3 * ScanCycles);
    checkOutput("idle_map", 32'(keyMap), 32'(0));
    checkOutput("idle_pulses", 32'(pulseCount), 32'(0));

    p0 = pulseCount;
    c0 = edgeCount;
    applyStimulus(9'b000100000, 10 * ScanCycles);
    checkOutput("k5_pulses", 32'(pulseCount - p0), 32'(1));
    checkOutput("k5_code", 32'(lastPulseCode), 32'(5));
    checkOutput("k5_latency_ok", 32'(((lastPulseEdge - c0) <= 2 * ScanCycles + 3) ? 1 : 0), 32'(1));
    checkOutput("k5_map", 32'(keyMap), 32'(9'b000100000));
    checkOutput("k5_held", 32'(keyHeld), 32'(1));
    p0 = pulseCount;
    applyStimulus(9'b0, 2 * ScanCycles + 3);
    checkOutput("k5_release_map", 32'(keyMap), 32'(0));
    checkOutput("k5_release_held", 32'(keyHeld), 32'(0));
    waitCycles(ScanCycles);
    checkOutput("k5_release_pulses", 32'(pulseCount - p0), 32'(0));

    p0 = pulseCount;
    for (int i = 0; i < 4; i++) applyStimulus((i % 2 == 0) ? 9'b1 : 9'b0, ScanCycles);
    checkOutput("bounce_pulses", 32'(pulseCount - p0), 32'(0));
    p0 = pulseCount;
    applyStimulus(9'b1, 4 * ScanCycles);
    checkOutput("bounce_settle_pulses", 32'(pulseCount - p0), 32'(1));
    checkOutput("bounce_code", 32'(lastPulseCode), 32'(0));
    applyStimulus(9'b0, 4 * ScanCycles);

    p0 = pulseCount;
    applyStimulus(9'b001000000, 4 * ScanCycles);
    checkOutput("k6_pulses", 32'(pulseCount - p0), 32'(1));
    checkOutput("k6_code", 32'(lastPulseCode), 32'(6));
    p0 = pulseCount;
    applyStimulus(9'b001000010, 4 * ScanCycles);
    checkOutput("k6k1_map", 32'(keyMap), 32'(9'b001000010));
    checkOutput("k6k1_pulses", 32'(pulseCount - p0), 32'(0));
    applyStimulus(9'b0, 4 * ScanCycles);
    p0 = pulseCount;
    applyStimulus(9'b000000010, 4 * ScanCycles);
    checkOutput("k1_pulses", 32'(pulseCount - p0), 32'(1));
    checkOutput("k1_code", 32'(lastPulseCode), 32'(1));
    applyStimulus(9'b0, 4 * ScanCycles);

    p0 = pulseCount;
    applyStimulus(9'b100000001, 4 * ScanCycles);
    checkOutput("k0k8_map", 32'(keyMap), 32'(9'b100000001));
    checkOutput("k0k8_pulses", 32'(pulseCount - p0), 32'(0));
    checkOutput("k0k8_code", 32'(keyCode), 32'(1));
    applyStimulus(9'b0, 4 * ScanCycles);

    applyStimulus(9'b000010000, 4 * ScanCycles);
    checkOutput("k4_code_before_reset", 32'(keyCode), 32'(4));
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (keyMatrixCol == 3'b101) found = 1;
    end
    checkOutput("col1_wait", 32'(found), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("midscan_reset");
    reset = 1'b1;
    p0 = pulseCount;
    waitCycles(3 * ScanCycles);
    checkOutput("k4_after_reset_pulses", 32'(pulseCount - p0), 32'(1));
    checkOutput("k4_after_reset_code", 32'(lastPulseCode), 32'(4));
    checkOutput("k4_after_reset_map", 32'(keyMap), 32'(9'b000010000));
    applyStimulus(9'b0, 4 * ScanCycles);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) k = '0;
      else if (sel < 8) k = 9'(1) << $urandom_range(0, 8);
      else k = 9'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      applyStimulus(k, $urandom_range(1, 40));
    end
    applyStimulus(9'b0, 4 * ScanCycles);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
